bp_cce_fetch_predictor: RTL and testbench

Owns the CCE fetch PC and next-PC prediction. Drives the instruction RAM read address, presents each fetched instruction to the decoder with a valid/ready handshake, and predicts branches either statically from the instruction predict bit or dynamically from a table of 2-bit saturating counters. Resolved-branch feedback from the execute stage trains the table and redirects fetch on a mispredict.

---
 rtl/bp_cce_fetch_predictor_if.sv | 32 +++
 rtl/bp_cce_fetch_predictor.sv | 84 ++++++++
 tb/tb_bp_cce_fetch_predictor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bp_cce_fetch_predictor_if.sv
// rtl/bp_cce_fetch_predictor_if.sv - fetch/decode/resolve signal bundle for the CCE fetch predictor
interface bp_cce_fetch_predictor_if #(
  parameter int width_p = 8
);
  logic               mode_i;
  logic [width_p-1:0] fetch_addr_o;
  logic               inst_branch_i;
  logic               inst_predict_i;
  logic [width_p-1:0] inst_target_i;
  logic               inst_v_o;
  logic               ready_i;
  logic [width_p-1:0] pc_o;
  logic               predicted_taken_o;
  logic [width_p-1:0] predicted_next_pc_o;
  logic               resolve_v_i;
  logic [width_p-1:0] resolve_pc_i;
  logic               resolve_taken_i;
  logic               resolve_mispredict_i;
  logic [width_p-1:0] resolve_next_pc_i;

  modport slave (
    input  mode_i, inst_branch_i, inst_predict_i, inst_target_i, ready_i,
           resolve_v_i, resolve_pc_i, resolve_taken_i, resolve_mispredict_i, resolve_next_pc_i,
    output fetch_addr_o, inst_v_o, pc_o, predicted_taken_o, predicted_next_pc_o
  );

  modport master (
    output mode_i, inst_branch_i, inst_predict_i, inst_target_i, ready_i,
           resolve_v_i, resolve_pc_i, resolve_taken_i, resolve_mispredict_i, resolve_next_pc_i,
    input  fetch_addr_o, inst_v_o, pc_o, predicted_taken_o, predicted_next_pc_o
  );
endinterface

// File: rtl/bp_cce_fetch_predictor.sv
// rtl/bp_cce_fetch_predictor.sv - CCE fetch PC owner with static/BHT next-PC prediction
module bp_cce_fetch_predictor #(
  parameter int                 width_p       = 8,
  parameter int                 bht_entries_p = 16,
  parameter logic [width_p-1:0] boot_pc_p     = '0
) (
  input logic                     clk_i,
  input logic                     reset_i,
  bp_cce_fetch_predictor_if.slave bus
);
  localparam int idx_w_lp = $clog2(bht_entries_p);

  logic [width_p-1:0]  fetch_pc_r;
  logic                booted_r;
  logic [1:0]          bht_r [bht_entries_p];

  logic [idx_w_lp-1:0] fetch_idx;
  logic [idx_w_lp-1:0] resolve_idx;
  logic                redirect;
  logic                stall;
  logic                taken;
  logic [width_p-1:0]  next_pc;
  logic                unused_resolve_pc_bits;

  assign fetch_idx              = fetch_pc_r[idx_w_lp-1:0];
  assign resolve_idx            = bus.resolve_pc_i[idx_w_lp-1:0];
  assign unused_resolve_pc_bits = ^bus.resolve_pc_i;

  // Prediction depends only on state and inst_*, never on ready_i.
  always_comb begin
    taken = 1'b0;
    if (bus.inst_branch_i) begin
      taken = bus.mode_i ? bht_r[fetch_idx][1] : bus.inst_predict_i;
    end
    next_pc = taken ? bus.inst_target_i : fetch_pc_r + width_p'(1);
  end

  always_comb begin
    redirect = bus.resolve_v_i & bus.resolve_mispredict_i;
    stall    = booted_r & ~redirect & ~bus.ready_i;

    bus.inst_v_o            = booted_r & ~redirect;
    bus.pc_o                = fetch_pc_r;
    bus.predicted_taken_o   = taken;
    bus.predicted_next_pc_o = next_pc;

    if (!booted_r) begin
      bus.fetch_addr_o = boot_pc_p;
    end else if (redirect) begin
      bus.fetch_addr_o = bus.resolve_next_pc_i;
    end else if (stall) begin
      bus.fetch_addr_o = fetch_pc_r;
    end else begin
      bus.fetch_addr_o = next_pc;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_r <= boot_pc_p;
      booted_r   <= 1'b0;
    end else begin
      booted_r <= 1'b1;
      if (booted_r) begin
        fetch_pc_r <= bus.fetch_addr_o;
      end
    end
  end

  // Counters train on every resolve regardless of mode or mispredict.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < bht_entries_p; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (bus.resolve_v_i) begin
      if (bus.resolve_taken_i && bht_r[resolve_idx] != 2'b11) begin
        bht_r[resolve_idx] <= bht_r[resolve_idx] + 2'b01;
      end else if (!bus.resolve_taken_i && bht_r[resolve_idx] != 2'b00) begin
        bht_r[resolve_idx] <= bht_r[resolve_idx] - 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_bp_cce_fetch_predictor.sv
// tb/tb_bp_cce_fetch_predictor.sv - directed scoreboard bench for bp_cce_fetch_predictor
module tb_bp_cce_fetch_predictor;
  logic clk;
  logic reset;

  bp_cce_fetch_predictor_if #(.width_p(8)) bus ();

  bp_cce_fetch_predictor #(
    .width_p      (8),
    .bht_entries_p(16),
    .boot_pc_p    (8'h10)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction RAM: registers the address, returns data the next cycle.
  logic       mem_br [256];
  logic       mem_pr [256];
  logic [7:0] mem_tg [256];
  logic [7:0] rd_addr;

  always @(posedge clk) rd_addr <= bus.fetch_addr_o;

  assign bus.inst_branch_i  = mem_br[rd_addr];
  assign bus.inst_predict_i = mem_pr[rd_addr];
  assign bus.inst_target_i  = mem_tg[rd_addr];

  typedef struct {
    string      tag;
    logic       v;
    logic [7:0] pc;
    logic       t;
    logic [7:0] n;
    logic [7:0] fa;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic resolve(input logic v, input logic [7:0] pc, input logic tk,
                         input logic misp, input logic [7:0] nxt);
    bus.resolve_v_i          = v;
    bus.resolve_pc_i         = pc;
    bus.resolve_taken_i      = tk;
    bus.resolve_mispredict_i = misp;
    bus.resolve_next_pc_i    = nxt;
  endtask

  // Push the expected outputs for the current cycle, then compare at the negedge.
  task automatic step(input string tag, input logic v, input logic [7:0] pc,
                      input logic t, input logic [7:0] n, input logic [7:0] fa);
    exp_t e;
    e.tag = tag; e.v = v; e.pc = pc; e.t = t; e.n = n; e.fa = fa;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    cmp({e.tag, ".inst_v"},  {7'd0, bus.inst_v_o},          {7'd0, e.v});
    cmp({e.tag, ".pc"},      bus.pc_o,                      e.pc);
    cmp({e.tag, ".taken"},   {7'd0, bus.predicted_taken_o}, {7'd0, e.t});
    cmp({e.tag, ".next_pc"}, bus.predicted_next_pc_o,       e.n);
    cmp({e.tag, ".fetch"},   bus.fetch_addr_o,              e.fa);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_br[i] = 1'b0;
      mem_pr[i] = 1'b0;
      mem_tg[i] = 8'h00;
    end
    mem_br[8'h20] = 1'b1;
    mem_pr[8'h20] = 1'b1;
    mem_tg[8'h20] = 8'h40;

    reset       = 1'b1;
    bus.mode_i  = 1'b0;
    bus.ready_i = 1'b1;
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    step("reset", 1'b0, 8'h10, 1'b0, 8'h11, 8'h10);
    reset = 1'b0;

    // Boot and sequential fetch
    step("boot",  1'b0, 8'h10, 1'b0, 8'h11, 8'h10);
    step("seq10", 1'b1, 8'h10, 1'b0, 8'h11, 8'h11);
    step("seq11", 1'b1, 8'h11, 1'b0, 8'h12, 8'h12);
    step("seq12", 1'b1, 8'h12, 1'b0, 8'h13, 8'h13);

    // Redirect to FF and wrap
    resolve(1'b1, 8'hEF, 1'b0, 1'b1, 8'hFF);
    step("redir_ff", 1'b0, 8'h13, 1'b0, 8'h14, 8'hFF);
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("wrap_ff", 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00);
    step("wrap_00", 1'b1, 8'h00, 1'b0, 8'h01, 8'h01);

    // Static prediction
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h20);
    step("redir_20a", 1'b0, 8'h01, 1'b0, 8'h02, 8'h20);
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("static_tk", 1'b1, 8'h20, 1'b1, 8'h40, 8'h40);
    mem_pr[8'h20] = 1'b0;
    step("tgt_40", 1'b1, 8'h40, 1'b0, 8'h41, 8'h41);
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h20);
    step("redir_20b", 1'b0, 8'h41, 1'b0, 8'h42, 8'h20);
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("static_nt", 1'b1, 8'h20, 1'b0, 8'h21, 8'h21);
    step("seq21", 1'b1, 8'h21, 1'b0, 8'h22, 8'h22);

    // Dynamic: train entry 0 up twice (01 -> 11)
    bus.mode_i = 1'b1;
    resolve(1'b1, 8'h20, 1'b1, 1'b0, 8'h00);
    step("train_t1", 1'b1, 8'h22, 1'b0, 8'h23, 8'h23);
    step("train_t2", 1'b1, 8'h23, 1'b0, 8'h24, 8'h24);
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h20);
    step("redir_20c", 1'b0, 8'h24, 1'b0, 8'h25, 8'h20);
    // Same-cycle not-taken resolve must not affect this prediction
    resolve(1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
    step("dyn_tk", 1'b1, 8'h20, 1'b1, 8'h40, 8'h40);
    step("train_n2", 1'b1, 8'h40, 1'b0, 8'h41, 8'h41);
    step("train_n3", 1'b1, 8'h41, 1'b0, 8'h42, 8'h42);
    step("train_n4", 1'b1, 8'h42, 1'b0, 8'h43, 8'h43);
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h20);
    step("redir_20d", 1'b0, 8'h43, 1'b0, 8'h44, 8'h20);
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("dyn_nt", 1'b1, 8'h20, 1'b0, 8'h21, 8'h21);

    // Mispredict while stalled, then a plain stall
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h30);
    step("redir_30", 1'b0, 8'h21, 1'b0, 8'h22, 8'h30);
    bus.ready_i = 1'b0;
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h50);
    step("stall_redir", 1'b0, 8'h30, 1'b0, 8'h31, 8'h50);
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("stall_50", 1'b1, 8'h50, 1'b0, 8'h51, 8'h50);
    bus.ready_i = 1'b1;
    step("go_50", 1'b1, 8'h50, 1'b0, 8'h51, 8'h51);

    // Reset mid-stream
    reset = 1'b1;
    step("rst_mid", 1'b0, 8'h10, 1'b0, 8'h11, 8'h10);
    reset = 1'b0;
    step("reboot", 1'b0, 8'h10, 1'b0, 8'h11, 8'h10);
    resolve(1'b1, 8'h20, 1'b1, 1'b0, 8'h00);
    step("re_seq10", 1'b1, 8'h10, 1'b0, 8'h11, 8'h11);
    resolve(1'b1, 8'hEF, 1'b1, 1'b1, 8'h20);
    step("redir_20e", 1'b0, 8'h11, 1'b0, 8'h12, 8'h20);
    resolve(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    // Counter reset to 01 plus one taken resolve -> 10 -> predicts taken
    step("ctr_reset", 1'b1, 8'h20, 1'b1, 8'h40, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
